// File: rtl/data_mem_param.sv
// Parametrised single-port data memory for the MEM stage: registered read, read-valid strobe,
// out-of-range address flag and a post-reset init sweep. Optional byte-lane writes: DMEM_BYTE_EN.
module data_mem_param #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 8,
  parameter logic [DATA_W-1:0] INIT_VAL = DATA_W'(2)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   mem_access_addr,
  input  logic [DATA_W-1:0]   mem_write_data,
  input  logic                mem_write_en,
  input  logic                mem_read_en,
`ifdef DMEM_BYTE_EN
  input  logic [DATA_W/8-1:0] mem_byte_en,
`endif
  output logic [DATA_W-1:0]   mem_read_data,
  output logic                mem_read_valid,
  output logic                mem_ready,
  output logic                mem_addr_err
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int LANES = DATA_W / 8;
  localparam logic [DEPTH_LOG2-1:0] LAST_IDX = '1;

  typedef enum logic {INIT, IDLE} state_t;

  logic [DATA_W-1:0] ram [DEPTH];

  state_t                state, state_nxt;
  logic [DEPTH_LOG2-1:0] cnt, cnt_nxt;
  logic                  init_we;

  logic                  in_range;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  wr_req, rd_req, wr_ok;

  logic [DATA_W-1:0]     rd_data_p1;
  logic                  vld_p1;
  logic                  err_p1;
  logic                  ready_p1;

  // Address decode: the word is implemented only when all bits above the index are zero.
  generate
    if (DEPTH_LOG2 < ADDR_W) begin : g_range
      assign in_range = ~|mem_access_addr[ADDR_W-1:DEPTH_LOG2];
    end else begin : g_full
      assign in_range = 1'b1;
    end
  endgenerate

  assign idx    = mem_access_addr[DEPTH_LOG2-1:0];
  assign wr_req = mem_write_en & ready_p1;
  assign rd_req = mem_read_en & ~mem_write_en & ready_p1;
  assign wr_ok  = wr_req & in_range;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    init_we   = 1'b0;
    case (state)
      INIT: begin
        init_we = 1'b1;
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST_IDX) state_nxt = IDLE;
      end
      IDLE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = INIT;
    endcase
  end

  // Array has no reset; the sweep and accepted writes share the single write port.
  always_ff @(posedge clk) begin
    if (init_we) begin
      ram[cnt] <= INIT_VAL;
    end else if (wr_ok) begin
`ifdef DMEM_BYTE_EN
      for (int i = 0; i < LANES; i++) begin
        if (mem_byte_en[i]) ram[idx][8*i +: 8] <= mem_write_data[8*i +: 8];
      end
`else
      ram[idx] <= mem_write_data;
`endif
    end
  end

  // Stage 1: registered read response, strobes and ready flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
      err_p1     <= 1'b0;
      ready_p1   <= 1'b0;
    end else begin
      vld_p1   <= rd_req;
      err_p1   <= (wr_req | rd_req) & ~in_range;
      ready_p1 <= (state_nxt == IDLE);
      if (rd_req) rd_data_p1 <= in_range ? ram[idx] : '0;
    end
  end

  assign mem_read_data  = rd_data_p1;
  assign mem_read_valid = vld_p1;
  assign mem_addr_err   = err_p1;
  assign mem_ready      = ready_p1;

endmodule

// File: tb/tb_data_mem_param.sv
// Scoreboard bench for data_mem_param: a reference array predicts every response,
// a separate negedge monitor pops and compares whenever the memory reports something.
module tb_data_mem_param;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 256;

  typedef struct {
    bit                vld;
    logic [DATA_W-1:0] data;
    bit                err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic                we, re;
  logic [DATA_W/8-1:0] be;
  logic [DATA_W-1:0]   mem_read_data;
  logic                mem_read_valid, mem_ready, mem_addr_err;

  always #5 clk = ~clk;

  data_mem_param dut (
    .clk(clk),
    .rst(rst),
    .mem_access_addr(addr),
    .mem_write_data(wdata),
    .mem_write_en(we),
    .mem_read_en(re),
`ifdef DMEM_BYTE_EN
    .mem_byte_en(be),
`endif
    .mem_read_data(mem_read_data),
    .mem_read_valid(mem_read_valid),
    .mem_ready(mem_ready),
    .mem_addr_err(mem_addr_err)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [DATA_W-1:0] model [DEPTH];
  exp_t exp_q[$];
  exp_t mon_e;
  logic [DATA_W-1:0] last_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: consumes one expected entry per reported response, otherwise data must hold.
  always @(negedge clk) begin
    if (!rst) begin
      last_rd = '0;
    end else if (mem_read_valid || mem_addr_err) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_output: valid=%0b err=%0b, expected no response at %0t",
                 mem_read_valid, mem_addr_err, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("read_valid", 32'(mem_read_valid), 32'(mon_e.vld));
        check("addr_err", 32'(mem_addr_err), 32'(mon_e.err));
        if (mon_e.vld) begin
          check("read_data", 32'(mem_read_data), 32'(mon_e.data));
          last_rd = mon_e.data;
        end else begin
          check("data_hold", 32'(mem_read_data), 32'(last_rd));
        end
      end
    end else begin
      check("data_hold", 32'(mem_read_data), 32'(last_rd));
    end
  end

  task automatic idle();
    we = 1'b0; re = 1'b0; addr = '0; wdata = '0; be = '1;
  endtask

  task automatic model_fill();
    for (int i = 0; i < DEPTH; i++) model[i] = 16'h0002;
  endtask

  // Issue one request for one cycle (memory assumed ready) and record the expected response.
  task automatic req(input bit w, input bit r, input logic [ADDR_W-1:0] a,
                     input logic [DATA_W-1:0] d, input logic [DATA_W/8-1:0] b);
    exp_t e;
    bit inr;
    we = w; re = r; addr = a; wdata = d; be = b;
    inr = (a < DEPTH);
    if (w) begin
      if (inr) begin
`ifdef DMEM_BYTE_EN
        for (int i = 0; i < DATA_W/8; i++)
          if (b[i]) model[a][8*i +: 8] = d[8*i +: 8];
`else
        model[a] = d;
`endif
      end else begin
        e.vld = 1'b0; e.data = '0; e.err = 1'b1;
        exp_q.push_back(e);
      end
    end else if (r) begin
      e.vld = 1'b1; e.data = inr ? model[a] : '0; e.err = !inr;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!mem_ready && n < 1000);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [ADDR_W-1:0] ra;
    idle();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data", 32'(mem_read_data), 32'h0);
    check("reset_valid", 32'(mem_read_valid), 32'h0);
    check("reset_ready", 32'(mem_ready), 32'h0);
    check("reset_err", 32'(mem_addr_err), 32'h0);

    // Requests during the sweep must be ignored entirely.
    re = 1'b1; addr = 16'h0100;
    rst = 1'b1;
    wait_ready(n);
    idle();
    check("ready_latency", 32'(n), 32'd256);
    model_fill();

    req(0, 1, 16'h0000, '0, '1);
    req(0, 1, 16'h00FF, '0, '1);
    req(1, 0, 16'h0009, 16'hBEEF, '1);
    req(0, 1, 16'h0009, '0, '1);
    req(1, 1, 16'h000A, 16'h1234, '1);
    req(0, 1, 16'h000A, '0, '1);
    req(0, 1, 16'h0100, '0, '1);
    req(1, 0, 16'h0100, 16'hFFFF, '1);
    req(0, 1, 16'h0000, '0, '1);
    req(1, 0, 16'h0003, 16'hAAAA, '1);
    req(1, 0, 16'h0003, 16'h5555, 2'b01);
    req(0, 1, 16'h0003, '0, '1);
    req(1, 0, 16'h0004, 16'h7777, 2'b00);
    req(0, 1, 16'h0004, '0, '1);

    for (int k = 0; k < 1500; k++) begin
      ra = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, DEPTH-1));
      req($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, ra,
          DATA_W'($urandom), 2'($urandom));
    end
    idle();
    repeat (2) @(posedge clk);
    #1;

    // Reset while a read response is being presented.
    req(1, 0, 16'h0007, 16'hC3C3, '1);
    req(0, 1, 16'h0007, '0, '1);
    idle();
    rst = 1'b0;
    #1;
    exp_q.delete();
    check("midread_data", 32'(mem_read_data), 32'h0);
    check("midread_valid", 32'(mem_read_valid), 32'h0);
    check("midread_ready", 32'(mem_ready), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Reset part-way through the sweep; it must restart from word 0.
    repeat (100) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midsweep_ready", 32'(mem_ready), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    wait_ready(n);
    check("ready_latency_again", 32'(n), 32'd256);
    model_fill();

    req(0, 1, 16'h0007, '0, '1);
    req(0, 1, 16'h0009, '0, '1);
    for (int k = 0; k < 200; k++) begin
      ra = ($urandom_range(0, 4) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, DEPTH-1));
      req($urandom_range(0, 1) == 0, 1'b1, ra, DATA_W'($urandom), 2'($urandom));
    end
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("pending_responses", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
